// File: rtl/dm4_route.sv
// Registered 1-to-4 valid/ready demultiplexer with a one-entry buffer and a delivery counter per channel.
// Optional broadcast to all four channels is enabled by defining DM4_BCAST_EN.
module dm4_route #(
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       sw,
  input  logic             bcast,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [W-1:0]     out_data0,
  output logic [W-1:0]     out_data1,
  output logic [W-1:0]     out_data2,
  output logic [W-1:0]     out_data3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [3:0]            full_r;
  logic [3:0][W-1:0]     data_r;
  logic [3:0][CNT_W-1:0] cnt_r;
  logic [3:0]            can_s;
  logic [3:0]            sel_s;
  logic [3:0]            dest_s;
  logic [3:0]            load_s;
  logic [3:0]            drain_s;
  logic                  in_ready_s;

`ifndef DM4_BCAST_EN
  logic bcast_unused_s;
  assign bcast_unused_s = bcast;
`endif

  // A channel can take a word when empty or when it is being drained this cycle.
  assign can_s   = ~full_r | out_ready;
  assign drain_s = full_r & out_ready;

  // One-hot decode of the destination select.
  always_comb begin
    case (sw)
      2'b00:   sel_s = 4'b0001;
      2'b01:   sel_s = 4'b0010;
      2'b10:   sel_s = 4'b0100;
      2'b11:   sel_s = 4'b1000;
      default: sel_s = 4'b0000;
    endcase
  end

  // Destination set and producer-side ready.
  always_comb begin
`ifdef DM4_BCAST_EN
    if (bcast) begin
      dest_s     = 4'b1111;
      in_ready_s = &can_s;
    end else begin
      dest_s     = sel_s;
      in_ready_s = |(can_s & sel_s);
    end
`else
    dest_s     = sel_s;
    in_ready_s = |(can_s & sel_s);
`endif
  end

  assign in_ready = in_ready_s;

  // Channels written by an accepted word this cycle.
  always_comb begin
    if (in_valid && in_ready_s) begin
      load_s = dest_s;
    end else begin
      load_s = 4'b0000;
    end
  end

  // Occupancy: a refill wins over a drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 4'b0000;
    end else begin
      full_r <= load_s | (full_r & ~drain_s);
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    // Holding register keeps its last word until refilled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_r[k] <= '0;
      end else if (load_s[k]) begin
        data_r[k] <= in_data;
      end else begin
        data_r[k] <= data_r[k];
      end
    end

    // Delivery counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r[k] <= '0;
      end else if (drain_s[k]) begin
        cnt_r[k] <= cnt_r[k] + CNT_W'(1);
      end else begin
        cnt_r[k] <= cnt_r[k];
      end
    end
  end

  assign out_valid = full_r;
  assign out_data0 = data_r[0];
  assign out_data1 = data_r[1];
  assign out_data2 = data_r[2];
  assign out_data3 = data_r[3];
  assign cnt0      = cnt_r[0];
  assign cnt1      = cnt_r[1];
  assign cnt2      = cnt_r[2];
  assign cnt3      = cnt_r[3];

endmodule

// File: tb/tb_dm4_route.sv
// Directed scoreboard bench for dm4_route; per-channel queues hold words expected on each output.
module tb_dm4_route;
  localparam int W     = 32;
  localparam int CNT_W = 8;
`ifdef DM4_BCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic [1:0]       sw = 2'b00;
  logic             bcast = 1'b0;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = 4'b1111;
  logic [W-1:0]     out_data0, out_data1, out_data2, out_data3;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  logic [W-1:0]     od [4];
  logic [CNT_W-1:0] oc [4];
  logic [W-1:0]     sb [4][$];
  logic [CNT_W-1:0] cnt_m [4];
  int               n_chk = 0;
  int               n_fail = 0;

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = cnt0;
  assign oc[1] = cnt1;
  assign oc[2] = cnt2;
  assign oc[3] = cnt3;

  always #5 clk = ~clk;

  dm4_route #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sw(sw), .bcast(bcast), .out_valid(out_valid),
    .out_ready(out_ready), .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3), .cnt0(cnt0), .cnt1(cnt1),
    .cnt2(cnt2), .cnt3(cnt3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      cnt_m[k] = '0;
    end
  endtask

  // Check outputs mid-cycle against the model, then advance model and clock together.
  task automatic cycle();
    logic [3:0] can_m, dest_m, vm;
    logic       rdy_m;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vm[k]    = (sb[k].size() != 0);
      can_m[k] = !vm[k] || out_ready[k];
    end
    dest_m = (BC && bcast) ? 4'b1111 : (4'b0001 << sw);
    rdy_m  = (BC && bcast) ? (&can_m) : can_m[sw];
    check("in_ready", {63'd0, in_ready}, {63'd0, rdy_m});
    check("out_valid", {60'd0, out_valid}, {60'd0, vm});
    for (int k = 0; k < 4; k++) begin
      if (vm[k]) check($sformatf("out_data%0d", k), {32'd0, od[k]}, {32'd0, sb[k][0]});
      check($sformatf("cnt%0d", k), {56'd0, oc[k]}, {56'd0, cnt_m[k]});
    end
    for (int k = 0; k < 4; k++) begin
      if (vm[k] && out_ready[k]) begin
        void'(sb[k].pop_front());
        cnt_m[k] = cnt_m[k] + 8'd1;
      end
    end
    if (in_valid && rdy_m) begin
      for (int k = 0; k < 4; k++) if (dest_m[k]) sb[k].push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [W-1:0] d);
    sw       = s;
    in_data  = d;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [CNT_W-1:0] c0_before;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {60'd0, out_valid}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_data%0d", k), {32'd0, od[k]}, 64'd0);
      check($sformatf("rst_cnt%0d", k), {56'd0, oc[k]}, 64'd0);
    end
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word to ch2
    out_ready = 4'b1111;
    send(2'b10, 32'hDEADBEEF);
    cycle();
    in_valid = 1'b0;
    check("single_valid", {60'd0, out_valid}, 64'h4);
    check("single_data2", {32'd0, out_data2}, 64'hDEADBEEF);
    cycle();
    check("single_valid_gone", {60'd0, out_valid}, 64'h0);
    check("single_cnt2", {56'd0, cnt2}, 64'd1);
    check("single_cnt0", {56'd0, cnt0}, 64'd0);
    cycle();

    // Backpressure isolation on ch1
    out_ready = 4'b1101;
    send(2'b01, 32'h11);
    cycle();
    send(2'b01, 32'h22);
    #1;
    check("bp_in_ready_ch1", {63'd0, in_ready}, 64'd0);
    cycle();
    send(2'b00, 32'h33);
    #1;
    check("bp_in_ready_ch0", {63'd0, in_ready}, 64'd1);
    cycle();
    in_valid = 1'b0;
    check("bp_ch0_data", {32'd0, out_data0}, 64'h33);
    check("bp_ch1_data", {32'd0, out_data1}, 64'h11);
    check("bp_valid", {60'd0, out_valid}, 64'h3);
    cycle();
    out_ready = 4'b1111;
    repeat (2) cycle();

    // Streaming 300 words to ch3
    for (int i = 0; i < 300; i++) begin
      send(2'b11, W'(i));
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("stream_cnt3", {56'd0, cnt3}, 64'd44);
    check("stream_empty", {60'd0, out_valid}, 64'h0);

    // Drain and refill ch0 in the same cycle
    out_ready = 4'b1110;
    send(2'b00, 32'hA);
    cycle();
    out_ready = 4'b1111;
    c0_before = cnt_m[0];
    send(2'b00, 32'hB);
    cycle();
    in_valid = 1'b0;
    check("dr_valid0", {63'd0, out_valid[0]}, 64'd1);
    check("dr_data0", {32'd0, out_data0}, 64'hB);
    check("dr_cnt0", {56'd0, cnt0}, {56'd0, c0_before + 8'd1});
    cycle();

    // Fill all channels then reset asynchronously mid-cycle
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      send(2'(k), 32'h100 + W'(k));
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("pre_rst_valid", {60'd0, out_valid}, 64'hF);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {60'd0, out_valid}, 64'h0);
    check("arst_cnts", {32'd0, cnt0, cnt1, cnt2, cnt3}, 64'd0);
    #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;

    // Broadcast against a stalled ch2
    out_ready = 4'b1011;
    send(2'b10, 32'h77);
    cycle();
    send(2'b01, 32'h55);
    bcast = 1'b1;
    #1;
    if (BC) begin
      check("bc_blocked", {63'd0, in_ready}, 64'd0);
      cycle();
      out_ready = 4'b1111;
      cycle();
      in_valid = 1'b0;
      bcast = 1'b0;
      check("bc_all_valid", {60'd0, out_valid}, 64'hF);
      check("bc_all_data", {out_data0 & out_data1, out_data2 & out_data3}, 64'h00000055_00000055);
      check("bc_data_or", {32'd0, out_data0 | out_data1 | out_data2 | out_data3}, 64'h55);
    end else begin
      check("nobc_ready", {63'd0, in_ready}, 64'd1);
      cycle();
      in_valid = 1'b0;
      bcast = 1'b0;
      check("nobc_valid", {60'd0, out_valid}, 64'h6);
      check("nobc_data1", {32'd0, out_data1}, 64'h55);
      out_ready = 4'b1111;
    end
    repeat (3) cycle();
    check("final_empty", {60'd0, out_valid}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
